// File: rtl/tns_link_scheduler_pkg.sv
// Shared types and helpers for the TNS link scheduler and its arbiter.
package tns_link_scheduler_pkg;

  typedef enum logic [0:0] {
    StInit = 1'b0,
    StRun  = 1'b1
  } sched_state_e;

  // Width of the TNS encoder datain bus; DATA_W must match it.
  localparam int unsigned EncDataW = 24;

  function automatic int unsigned src_width(input int unsigned num_ch);
    int unsigned w;
    w = 1;
    if (num_ch > 2) w = $clog2(num_ch);
    return w;
  endfunction

endpackage

// File: rtl/tns_rr_arbiter.sv
// Combinational round-robin arbiter: the owner keeps priority until its burst
// expires, then the search starts after it and the owner is considered last.
module tns_rr_arbiter #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned SRC_W  = 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SRC_W-1:0]  ptr,
  input  logic              expired,
  output logic [NUM_CH-1:0] gnt,
  output logic [SRC_W-1:0]  idx,
  output logic              any
);

  logic [SRC_W-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    if (req[ptr] && !expired) begin
      any = 1'b1;
      idx = ptr;
    end else begin
      // i == NUM_CH lands back on the owner, so it is checked last.
      for (int i = 1; i <= int'(NUM_CH); i++) begin
        cand = SRC_W'((int'(ptr) + i) % int'(NUM_CH));
        if (!any && req[cand]) begin
          any = 1'b1;
          idx = cand;
        end
      end
    end
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/tns_link_scheduler.sv
// Arbitrates NUM_CH sources onto one TNS encoder, flushes the encoder after
// reset and tags each codeword with its source, aligned to encoder codeout.
module tns_link_scheduler
  import tns_link_scheduler_pkg::*;
#(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned DATA_W      = EncDataW,
  parameter int unsigned MAX_BURST   = 4,
  parameter int unsigned INIT_CYCLES = 3,
  parameter int unsigned SRC_W       = src_width(NUM_CH)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic                     link_ready,
  output logic [DATA_W-1:0]        enc_datain,
  output logic                     code_valid,
  output logic [SRC_W-1:0]         code_src,
  output logic                     link_up
);

  localparam int unsigned BurstW = $clog2(MAX_BURST + 1);
  localparam int unsigned InitW  = $clog2(INIT_CYCLES + 1);
  localparam logic [BurstW-1:0] BurstMax = BurstW'(MAX_BURST);
  localparam logic [InitW-1:0]  InitLast = InitW'(INIT_CYCLES - 1);

  sched_state_e      state_q, state_d;
  logic [InitW-1:0]  init_cnt_q, init_cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [SRC_W-1:0]  rr_q, rr_d;
  logic [BurstW-1:0] burst_q, burst_d;
  logic              v1_q, v1_d, v2_q, v2_d;
  logic [SRC_W-1:0]  src1_q, src1_d, src2_q, src2_d;

  logic [NUM_CH-1:0] gnt;
  logic [SRC_W-1:0]  gnt_idx;
  logic              gnt_any;
  logic              accept;

  tns_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .SRC_W  (SRC_W)
  ) u_arb (
    .req     (in_valid),
    .ptr     (rr_q),
    .expired (burst_q >= BurstMax),
    .gnt     (gnt),
    .idx     (gnt_idx),
    .any     (gnt_any)
  );

  // Gated by reset_n so no source sees a handshake that reset will discard.
  assign accept   = (state_q == StRun) && link_ready && reset_n && gnt_any;
  assign in_ready = accept ? gnt : '0;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    data_d     = data_q;
    rr_d       = rr_q;
    burst_d    = burst_q;
    v1_d       = accept;
    src1_d     = gnt_idx;
    v2_d       = v1_q;
    src2_d     = src1_q;
    unique case (state_q)
      StInit: begin
        data_d     = '0;
        init_cnt_d = init_cnt_q + InitW'(1);
        if (init_cnt_q == InitLast) state_d = StRun;
      end
      StRun: begin
        if (accept) begin
          data_d = in_data[gnt_idx*DATA_W +: DATA_W];
          if (gnt_idx == rr_q) begin
            // A lone owner keeps going; the count just saturates.
            if (burst_q != BurstMax) burst_d = burst_q + BurstW'(1);
          end else begin
            burst_d = BurstW'(1);
            rr_d    = gnt_idx;
          end
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= StInit;
      init_cnt_q <= '0;
      data_q     <= '0;
      rr_q       <= '0;
      burst_q    <= '0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      src1_q     <= '0;
      src2_q     <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      data_q     <= data_d;
      rr_q       <= rr_d;
      burst_q    <= burst_d;
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      src1_q     <= src1_d;
      src2_q     <= src2_d;
    end
  end

  assign enc_datain = data_q;
  assign code_valid = v2_q;
  assign code_src   = src2_q;
  assign link_up    = (state_q == StRun);

endmodule

// File: tb/tb_tns_link_scheduler.sv
// Bench for tns_link_scheduler: directed vectors plus random traffic against
// a behavioural model of the arbitration and pipeline rules.
module tb_tns_link_scheduler;

  localparam int NUM_CH = 2;
  localparam int DATA_W = 24;
  localparam int MAX_B  = 4;
  localparam int INIT_C = 3;

  logic                     clock;
  logic                     reset_n;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_ready;
  logic                     link_ready;
  logic [DATA_W-1:0]        enc_datain;
  logic                     code_valid;
  logic [0:0]               code_src;
  logic                     link_up;

  tns_link_scheduler #(
    .NUM_CH      (NUM_CH),
    .DATA_W      (DATA_W),
    .MAX_BURST   (MAX_B),
    .INIT_CYCLES (INIT_C),
    .SRC_W       (1)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .link_ready (link_ready),
    .enc_datain (enc_datain),
    .code_valid (code_valid),
    .code_src   (code_src),
    .link_up    (link_up)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state.
  bit          m_up;
  int          m_cnt;
  int          m_rr;
  int          m_burst;
  logic [23:0] m_data;
  bit          pv[2];
  int          ps[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_grant();
    if (!reset_n || !m_up || !link_ready) return -1;
    if (in_valid[m_rr] && m_burst < MAX_B) return m_rr;
    for (int k = 1; k <= NUM_CH; k++) begin
      int c;
      c = (m_rr + k) % NUM_CH;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_check();
    int g;
    logic [NUM_CH-1:0] er;
    g  = m_grant();
    er = (g >= 0) ? (NUM_CH'(1) << g) : '0;
    chk("in_ready", 32'(in_ready), 32'(er));
    chk("enc_datain", 32'(enc_datain), 32'(m_data));
    chk("code_valid", 32'(code_valid), 32'(pv[1]));
    chk("link_up", 32'(link_up), 32'(m_up));
    if (pv[1]) chk("code_src", 32'(code_src), 32'(ps[1]));
  endtask

  task automatic advance();
    int g;
    g = m_grant();
    @(posedge clock);
    if (!reset_n) begin
      m_up = 0; m_cnt = 0; m_rr = 0; m_burst = 0; m_data = '0;
      pv[0] = 0; pv[1] = 0; ps[0] = 0; ps[1] = 0;
    end else begin
      pv[1] = pv[0]; ps[1] = ps[0];
      pv[0] = (g >= 0); ps[0] = (g >= 0) ? g : 0;
      if (!m_up) begin
        m_cnt++;
        m_data = '0;
        if (m_cnt == INIT_C) m_up = 1;
      end else if (g >= 0) begin
        m_data = in_data[g*DATA_W +: DATA_W];
        if (g == m_rr) m_burst = (m_burst < MAX_B) ? m_burst + 1 : MAX_B;
        else begin
          m_burst = 1;
          m_rr    = g;
        end
      end
    end
    #1;
  endtask

  task automatic step();
    @(negedge clock);
    model_check();
    advance();
  endtask

  typedef struct {
    logic [1:0] valid;
    logic       lr;
    logic [1:0] rdy;
    logic       cv;
    logic       src;
  } vec_t;

  vec_t tbl[16];

  initial begin
    // Contention with a 3-cycle stall mid-way through ch1's burst.
    tbl[0]  = '{2'b11, 1'b1, 2'b01, 1'b0, 1'b0};
    tbl[1]  = '{2'b11, 1'b1, 2'b01, 1'b0, 1'b0};
    tbl[2]  = '{2'b11, 1'b1, 2'b01, 1'b1, 1'b0};
    tbl[3]  = '{2'b11, 1'b1, 2'b01, 1'b1, 1'b0};
    tbl[4]  = '{2'b11, 1'b1, 2'b10, 1'b1, 1'b0};
    tbl[5]  = '{2'b11, 1'b1, 2'b10, 1'b1, 1'b0};
    tbl[6]  = '{2'b11, 1'b0, 2'b00, 1'b1, 1'b1};
    tbl[7]  = '{2'b11, 1'b0, 2'b00, 1'b1, 1'b1};
    tbl[8]  = '{2'b11, 1'b0, 2'b00, 1'b0, 1'b0};
    tbl[9]  = '{2'b11, 1'b1, 2'b10, 1'b0, 1'b0};
    tbl[10] = '{2'b11, 1'b1, 2'b10, 1'b0, 1'b0};
    tbl[11] = '{2'b11, 1'b1, 2'b01, 1'b1, 1'b1};
    tbl[12] = '{2'b11, 1'b1, 2'b01, 1'b1, 1'b1};
    tbl[13] = '{2'b00, 1'b1, 2'b00, 1'b1, 1'b0};
    tbl[14] = '{2'b00, 1'b1, 2'b00, 1'b1, 1'b0};
    tbl[15] = '{2'b00, 1'b1, 2'b00, 1'b0, 1'b0};

    reset_n    = 1'b0;
    in_valid   = '0;
    in_data    = '0;
    link_ready = 1'b1;
    m_up = 0; m_cnt = 0; m_rr = 0; m_burst = 0; m_data = '0;
    pv[0] = 0; pv[1] = 0; ps[0] = 0; ps[1] = 0;

    // Reset then idle: link_up after the third post-reset cycle.
    step();
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("init_link_up", 32'(link_up), 32'd0);
      chk("init_in_ready", 32'(in_ready), 32'd0);
      model_check();
      advance();
    end
    @(negedge clock);
    chk("link_up_rise", 32'(link_up), 32'd1);
    model_check();
    advance();

    // Single word on ch0.
    in_valid = 2'b01;
    in_data  = {24'h123456, 24'h00ABCD};
    step();
    in_valid = '0;
    in_data  = '0;
    @(negedge clock);
    chk("single_enc", 32'(enc_datain), 32'h00ABCD);
    chk("single_cv_early", 32'(code_valid), 32'd0);
    model_check();
    advance();
    @(negedge clock);
    chk("single_cv", 32'(code_valid), 32'd1);
    chk("single_src", 32'(code_src), 32'd0);
    model_check();
    advance();
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("single_hold_enc", 32'(enc_datain), 32'h00ABCD);
      chk("single_hold_cv", 32'(code_valid), 32'd0);
      model_check();
      advance();
    end

    // Fresh start for the contention/backpressure table.
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    for (int i = 0; i < INIT_C; i++) step();
    for (int i = 0; i < 16; i++) begin
      in_valid   = tbl[i].valid;
      link_ready = tbl[i].lr;
      in_data    = {24'($urandom), 24'($urandom)};
      @(negedge clock);
      chk($sformatf("tbl%0d_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
      chk($sformatf("tbl%0d_cv", i), 32'(code_valid), 32'(tbl[i].cv));
      if (tbl[i].cv) chk($sformatf("tbl%0d_src", i), 32'(code_src), 32'(tbl[i].src));
      model_check();
      advance();
    end

    // Lone requester: ch1 accepted every cycle despite burst limit.
    in_valid = 2'b10;
    for (int i = 0; i < 10; i++) begin
      in_data = {24'($urandom), 24'($urandom)};
      @(negedge clock);
      chk($sformatf("lone%0d_ready", i), 32'(in_ready), 32'b10);
      model_check();
      advance();
    end
    in_valid = '0;
    step();
    step();

    // Reset one edge after an accept.
    in_valid = 2'b11;
    step();
    reset_n = 1'b0;
    @(negedge clock);
    chk("rst_cv", 32'(code_valid), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    model_check();
    advance();
    reset_n  = 1'b1;
    in_valid = '0;
    for (int i = 0; i < INIT_C; i++) begin
      @(negedge clock);
      chk("after_rst_cv", 32'(code_valid), 32'd0);
      chk("after_rst_link_up", 32'(link_up), 32'd0);
      model_check();
      advance();
    end

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset_n    = ($urandom_range(0, 79) != 0);
      in_valid   = NUM_CH'($urandom);
      link_ready = ($urandom_range(0, 3) != 0);
      in_data    = {24'($urandom), 24'($urandom)};
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
